// File: rtl/zacore_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the fetch/data
// memory arbiter.
//   master : arbiter view (samples requests and memory responses, drives
//            acks, read data and the registered memory bus)
//   slave  : environment view (requesters plus memory)
// Member names keep their original i_/o_ prefixes, which are relative to
// the arbiter, so existing hookups carry over unchanged.
interface zacore_mem_arbiter_if;
  logic        i_fetch_req;
  logic [31:0] i_fetch_addr;
  logic        o_fetch_ack;
  logic [31:0] o_inst_read;
  logic        i_read_req;
  logic        i_write_req;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_write;
  logic [3:0]  i_data_write_mask;
  logic        o_read_ack;
  logic        o_write_ack;
  logic [31:0] o_data_read;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_owner_data;

  modport master (
    input  i_fetch_req, i_fetch_addr,
    input  i_read_req, i_write_req, i_data_addr, i_data_write, i_data_write_mask,
    input  i_mem_ack, i_mem_rdata,
    output o_fetch_ack, o_inst_read,
    output o_read_ack, o_write_ack, o_data_read,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output o_owner_data
  );

  modport slave (
    output i_fetch_req, i_fetch_addr,
    output i_read_req, i_write_req, i_data_addr, i_data_write, i_data_write_mask,
    output i_mem_ack, i_mem_rdata,
    input  o_fetch_ack, o_inst_read,
    input  o_read_ack, o_write_ack, o_data_read,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  o_owner_data
  );
endinterface

// File: rtl/zacore_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between the instruction fetch
// requester and the data (read/write) requester. One transaction at a time;
// address, write data and mask are registered at grant, and the memory ack
// plus read data are steered back to the owner combinationally.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous reset, active-low
//   bus    : zacore_mem_arbiter_if.master (requests, acks, memory bus)
// Parameters:
//   DATA_PRIORITY : 1 = data wins simultaneous requests, 0 = fetch wins
//   STARVE_LIMIT  : consecutive losses (1-15) before the non-preferred
//                   requester is forced through
module zacore_mem_arbiter #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  zacore_mem_arbiter_if.master   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_FETCH,
    BUSY_DATA
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;

  logic        data_pend;
  logic        both_pend;
  logic        starved;
  logic        grant_data;
  logic        grant_fetch;
  logic        take_write;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        owner_q;

  logic        fetch_ack;
  logic        read_ack;
  logic        write_ack;
  logic [31:0] inst_read;
  logic [31:0] data_read;

  // Grant decision; only acted on while IDLE.
  always_comb begin
    data_pend  = bus.i_read_req | bus.i_write_req;
    both_pend  = bus.i_fetch_req & data_pend;
    starved    = (starve_cnt == LIMIT);
    grant_data = 1'b0;
    if (both_pend) begin
      // Starvation flips the preference for exactly one grant.
      grant_data = DATA_PRIORITY ? ~starved : starved;
    end else begin
      grant_data = data_pend;
    end
    grant_fetch = bus.i_fetch_req & ~grant_data;
    // Write beats read when both are raised; the read stays pending.
    take_write  = grant_data & bus.i_write_req;
  end

  // State and starvation counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (grant_data) begin
          state_nxt = BUSY_DATA;
        end else if (grant_fetch) begin
          state_nxt = BUSY_FETCH;
        end
        // Counter only moves on contested grants; a lone requester leaves it.
        if (both_pend) begin
          if (grant_data == DATA_PRIORITY) begin
            if (!starved) begin
              starve_nxt = starve_cnt + 4'd1;
            end
          end else begin
            starve_nxt = '0;
          end
        end
      end
      BUSY_FETCH, BUSY_DATA: begin
        if (bus.i_mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory-bus fields, captured at grant and held until ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      owner_q     <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_data || grant_fetch) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= take_write;
        mem_addr_q  <= grant_data ? bus.i_data_addr : bus.i_fetch_addr;
        mem_wdata_q <= take_write ? bus.i_data_write : '0;
        mem_wmask_q <= take_write ? bus.i_data_write_mask : '0;
        owner_q     <= grant_data;
      end
    end else if (bus.i_mem_ack) begin
      mem_req_q <= 1'b0;
    end
  end

  // Output logic: acks and read data routed to the current owner only.
  always_comb begin
    fetch_ack = (state == BUSY_FETCH) & bus.i_mem_ack;
    read_ack  = (state == BUSY_DATA) & bus.i_mem_ack & ~mem_we_q;
    write_ack = (state == BUSY_DATA) & bus.i_mem_ack & mem_we_q;
    inst_read = fetch_ack ? bus.i_mem_rdata : '0;
    data_read = read_ack  ? bus.i_mem_rdata : '0;
  end

  assign bus.o_fetch_ack  = fetch_ack;
  assign bus.o_inst_read  = inst_read;
  assign bus.o_read_ack   = read_ack;
  assign bus.o_write_ack  = write_ack;
  assign bus.o_data_read  = data_read;
  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_we     = mem_we_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_wdata  = mem_wdata_q;
  assign bus.o_mem_wmask  = mem_wmask_q;
  assign bus.o_owner_data = owner_q;

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Directed bench for zacore_mem_arbiter. Two instances: dut_a with data
// priority, dut_b with fetch priority. Both see the same requests; only the
// selected one receives memory acks and is observed.
module tb_zacore_mem_arbiter;

  logic clk;
  logic rst_n;
  logic sel;
  int unsigned cyc;

  logic        fetch_req, read_req, write_req;
  logic [31:0] fetch_addr, data_addr, data_write;
  logic [3:0]  data_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned total, bad;

  // Memory / requester model controls.
  logic        mem_en;
  int unsigned ack_delay;
  int unsigned wcnt;
  logic        in_txn;
  logic [31:0] rdata_base;
  logic        keep_fetch, keep_read;

  // Grant log (sampled at first cycle of o_mem_req) and completion log.
  logic        glog_owner[$];
  logic        glog_we[$];
  logic [31:0] glog_addr[$];
  logic [31:0] glog_wdata[$];
  logic [3:0]  glog_mask[$];
  int unsigned glog_cyc[$];
  logic [2:0]  clog_acks[$];
  logic [31:0] clog_inst[$];
  logic [31:0] clog_data[$];
  int unsigned clog_cyc[$];

  zacore_mem_arbiter_if bus_a ();
  zacore_mem_arbiter_if bus_b ();

  zacore_mem_arbiter #(.DATA_PRIORITY(1'b1), .STARVE_LIMIT(4)) dut_a (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_a)
  );

  zacore_mem_arbiter #(.DATA_PRIORITY(1'b0), .STARVE_LIMIT(4)) dut_b (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_b)
  );

  assign bus_a.i_fetch_req       = fetch_req;
  assign bus_a.i_fetch_addr      = fetch_addr;
  assign bus_a.i_read_req        = read_req;
  assign bus_a.i_write_req       = write_req;
  assign bus_a.i_data_addr       = data_addr;
  assign bus_a.i_data_write      = data_write;
  assign bus_a.i_data_write_mask = data_mask;
  assign bus_a.i_mem_ack         = mem_ack & ~sel;
  assign bus_a.i_mem_rdata       = mem_rdata;

  assign bus_b.i_fetch_req       = fetch_req;
  assign bus_b.i_fetch_addr      = fetch_addr;
  assign bus_b.i_read_req        = read_req;
  assign bus_b.i_write_req       = write_req;
  assign bus_b.i_data_addr       = data_addr;
  assign bus_b.i_data_write      = data_write;
  assign bus_b.i_data_write_mask = data_mask;
  assign bus_b.i_mem_ack         = mem_ack & sel;
  assign bus_b.i_mem_rdata       = mem_rdata;

  logic        m_req, m_we, m_owner, m_fack, m_rack, m_wack;
  logic [31:0] m_addr, m_wdata, m_inst, m_data;
  logic [3:0]  m_mask;

  assign m_req   = sel ? bus_b.o_mem_req    : bus_a.o_mem_req;
  assign m_we    = sel ? bus_b.o_mem_we     : bus_a.o_mem_we;
  assign m_owner = sel ? bus_b.o_owner_data : bus_a.o_owner_data;
  assign m_fack  = sel ? bus_b.o_fetch_ack  : bus_a.o_fetch_ack;
  assign m_rack  = sel ? bus_b.o_read_ack   : bus_a.o_read_ack;
  assign m_wack  = sel ? bus_b.o_write_ack  : bus_a.o_write_ack;
  assign m_addr  = sel ? bus_b.o_mem_addr   : bus_a.o_mem_addr;
  assign m_wdata = sel ? bus_b.o_mem_wdata  : bus_a.o_mem_wdata;
  assign m_inst  = sel ? bus_b.o_inst_read  : bus_a.o_inst_read;
  assign m_data  = sel ? bus_b.o_data_read  : bus_a.o_data_read;
  assign m_mask  = sel ? bus_b.o_mem_wmask  : bus_a.o_mem_wmask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: memory model acts at the falling edge, checks happen 1 later.
  task automatic cycle();
    @(negedge clk);
    if (mem_en) begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (m_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt   = 0;
          glog_owner.push_back(m_owner);
          glog_we.push_back(m_we);
          glog_addr.push_back(m_addr);
          glog_wdata.push_back(m_wdata);
          glog_mask.push_back(m_mask);
          glog_cyc.push_back(cyc);
        end
        if (wcnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_base ^ 32'(glog_owner.size() - 1);
          in_txn    = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        in_txn = 1'b0;
      end
    end
    #1;
    if (mem_en && mem_ack) begin
      clog_acks.push_back({m_fack, m_rack, m_wack});
      clog_inst.push_back(m_inst);
      clog_data.push_back(m_data);
      clog_cyc.push_back(cyc);
      if (m_fack && !keep_fetch) fetch_req = 1'b0;
      if (m_rack && !keep_read)  read_req  = 1'b0;
      if (m_wack)                write_req = 1'b0;
    end
  endtask

  task automatic wait_done(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (clog_acks.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check_eq({tag, "_done"}, 32'(clog_acks.size()), n);
  endtask

  task automatic clear_logs();
    glog_owner.delete(); glog_we.delete(); glog_addr.delete();
    glog_wdata.delete(); glog_mask.delete(); glog_cyc.delete();
    clog_acks.delete(); clog_inst.delete(); clog_data.delete(); clog_cyc.delete();
    in_txn = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    fetch_req = 1'b0; read_req = 1'b0; write_req = 1'b0;
    keep_fetch = 1'b0; keep_read = 1'b0;
    mem_ack = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"},   m_req,   0);
    check_eq({tag, "_we"},    m_we,    0);
    check_eq({tag, "_addr"},  m_addr,  0);
    check_eq({tag, "_wdata"}, m_wdata, 0);
    check_eq({tag, "_mask"},  m_mask,  0);
    check_eq({tag, "_owner"}, m_owner, 0);
    check_eq({tag, "_acks"},  {m_fack, m_rack, m_wack}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    sel = 1'b0; mem_en = 1'b1; ack_delay = 0; rdata_base = '0;
    fetch_addr = '0; data_addr = '0; data_write = '0; data_mask = '0;
    mem_rdata = '0; in_txn = 1'b0; wcnt = 0;
    reset_all();
    check_idle_outputs("rst_a");

    // 1: lone fetch, memory acks two cycles after o_mem_req rises.
    clear_logs();
    ack_delay  = 2;
    rdata_base = 32'hDEAD_BEEF;
    cycle();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
    check_eq("t1_req_pre", m_req, 0);
    cycle();
    check_eq("t1_req_up", m_req, 1);
    check_eq("t1_addr", m_addr, 32'h100);
    check_eq("t1_we", m_we, 0);
    check_eq("t1_mask", m_mask, 0);
    wait_done(1, 20, "t1");
    check_eq("t1_ack_lat", clog_cyc[0] - glog_cyc[0], 2);
    check_eq("t1_acks", clog_acks[0], 3'b100);
    check_eq("t1_inst", clog_inst[0], 32'hDEAD_BEEF);
    check_eq("t1_data0", clog_data[0], 0);
    cycle();
    check_eq("t1_req_down", m_req, 0);
    check_eq("t1_fack_off", m_fack, 0);
    check_eq("t1_inst_off", m_inst, 0);

    // 2: simultaneous fetch and write, data priority, immediate acks.
    reset_all();
    clear_logs();
    ack_delay  = 0;
    rdata_base = 32'hCAFE_0000;
    cycle();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0200;
    write_req = 1'b1; data_addr = 32'h8000_0004;
    data_write = 32'h1234_5678; data_mask = 4'b0011;
    wait_done(2, 40, "t2");
    check_eq("t2_g0_owner", glog_owner[0], 1);
    check_eq("t2_g0_we", glog_we[0], 1);
    check_eq("t2_g0_addr", glog_addr[0], 32'h8000_0004);
    check_eq("t2_g0_wdata", glog_wdata[0], 32'h1234_5678);
    check_eq("t2_g0_mask", glog_mask[0], 4'b0011);
    check_eq("t2_c0_acks", clog_acks[0], 3'b001);
    check_eq("t2_g1_owner", glog_owner[1], 0);
    check_eq("t2_g1_we", glog_we[1], 0);
    check_eq("t2_g1_addr", glog_addr[1], 32'h200);
    check_eq("t2_g1_mask", glog_mask[1], 0);
    check_eq("t2_c1_acks", clog_acks[1], 3'b100);
    check_eq("t2_c1_inst", clog_inst[1], 32'hCAFE_0001);
    check_eq("t2_gap", glog_cyc[1] - glog_cyc[0], 2);

    // 3: fetch and read both held; starvation forces every 5th grant to fetch.
    reset_all();
    clear_logs();
    ack_delay  = 0;
    rdata_base = 32'h1111_0000;
    keep_fetch = 1'b1; keep_read = 1'b1;
    cycle();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0300;
    read_req  = 1'b1; data_addr  = 32'h0000_1000;
    wait_done(10, 60, "t3");
    keep_fetch = 1'b0; keep_read = 1'b0;
    fetch_req = 1'b0; read_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic exp_owner;
      exp_owner = !(i == 4 || i == 9);
      check_eq($sformatf("t3_owner%0d", i), glog_owner[i], exp_owner);
    end
    check_eq("t3_c0_acks", clog_acks[0], 3'b010);
    check_eq("t3_c0_data", clog_data[0], 32'h1111_0000);
    check_eq("t3_c4_acks", clog_acks[4], 3'b100);
    check_eq("t3_c4_inst", clog_inst[4], 32'h1111_0004);
    check_eq("t3_c5_addr", glog_addr[5], 32'h1000);
    repeat (4) cycle();
    check_eq("t3_no_extra", 32'(glog_owner.size()), 10);

    // 4: read and write raised together; write first, then the read.
    reset_all();
    clear_logs();
    ack_delay  = 1;
    rdata_base = 32'h0BAD_F00D;
    cycle();
    read_req = 1'b1; write_req = 1'b1; data_addr = 32'h0000_0040;
    data_write = 32'hA5A5_A5A5; data_mask = 4'b1111;
    wait_done(2, 40, "t4");
    check_eq("t4_g0_we", glog_we[0], 1);
    check_eq("t4_g0_mask", glog_mask[0], 4'b1111);
    check_eq("t4_c0_acks", clog_acks[0], 3'b001);
    check_eq("t4_c0_data", clog_data[0], 0);
    check_eq("t4_g1_we", glog_we[1], 0);
    check_eq("t4_g1_addr", glog_addr[1], 32'h40);
    check_eq("t4_g1_wdata", glog_wdata[1], 0);
    check_eq("t4_g1_mask", glog_mask[1], 0);
    check_eq("t4_c1_acks", clog_acks[1], 3'b010);
    check_eq("t4_c1_data", clog_data[1], 32'h0BAD_F00C);

    // 5: reset while a data read is outstanding; a stray ack is ignored.
    reset_all();
    clear_logs();
    mem_en = 1'b0;
    mem_ack = 1'b0;
    cycle();
    read_req = 1'b1; data_addr = 32'h0000_0044;
    cycle();
    cycle();
    check_eq("t5_busy_req", m_req, 1);
    check_eq("t5_busy_owner", m_owner, 1);
    rst_n = 1'b0;
    cycle();
    check_idle_outputs("t5_rst");
    rst_n = 1'b1; read_req = 1'b0;
    cycle();
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check_eq("t5_stray_acks", {m_fack, m_rack, m_wack}, 0);
    check_eq("t5_stray_data", m_data, 0);
    cycle();
    mem_ack = 1'b0;
    cycle();
    check_eq("t5_still_idle", m_req, 0);
    mem_en = 1'b1;

    // 6: fetch priority; read forced through after four fetch wins.
    sel = 1'b1;
    reset_all();
    check_idle_outputs("rst_b");
    clear_logs();
    ack_delay  = 0;
    rdata_base = 32'h7700_0000;
    keep_fetch = 1'b1;
    cycle();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0500;
    read_req  = 1'b1; data_addr  = 32'h0000_0600;
    wait_done(5, 40, "t6");
    keep_fetch = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t6_owner%0d", i), glog_owner[i], 0);
    end
    check_eq("t6_owner4", glog_owner[4], 1);
    check_eq("t6_c3_acks", clog_acks[3], 3'b100);
    check_eq("t6_c4_acks", clog_acks[4], 3'b010);
    check_eq("t6_c4_data", clog_data[4], 32'h7700_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zacore_mem_arbiter.md
Name: zacore_mem_arbiter

Overview:
- Shares one single-port memory bus between the core's fetch requester and data (read/write) requester.
- Sits between the core pipeline and the memory system.
- Grants one transaction at a time, registers the address, write data and mask at grant, and routes the ack and read data back to the owner.
- Priority is configurable, and a starvation limit guarantees fetch forward progress.

Parameters:
DATA_PRIORITY, 1, 1: data wins simultaneous requests; 0: fetch wins.
STARVE_LIMIT, 4, number of consecutive losing arbitrations (range 1-15) after which the lower-priority requester is forced to win.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_fetch_req  in  1  fetch request; held high, address stable, until o_fetch_ack
i_fetch_addr  in  32  fetch address
o_fetch_ack  out  1  one-cycle fetch completion
o_inst_read  out  32  instruction word; valid only while o_fetch_ack=1
i_read_req  in  1  data read request
i_write_req  in  1  data write request
i_data_addr  in  32  data address
i_data_write  in  32  write data
i_data_write_mask  in  4  byte enables; bit n = byte n
o_read_ack  out  1  one-cycle read completion
o_write_ack  out  1  one-cycle write completion
o_data_read  out  32  read data; valid only while o_read_ack=1
o_mem_req  out  1  bus request; high for the whole transaction
o_mem_we  out  1  1 = write
o_mem_addr  out  32  registered address
o_mem_wdata  out  32  registered write data
o_mem_wmask  out  4  registered mask; 4'b0000 on reads and fetches
i_mem_ack  in  1  one-cycle completion pulse from memory
i_mem_rdata  in  32  read data; valid with i_mem_ack
o_owner_data  out  1  debug: 1 = current/last grant was the data requester

Behaviour:
- Reset (i_rst=0 at a rising edge):
  - State returns to IDLE and the starve counter clears.
  - o_mem_req, o_mem_we, all acks and o_owner_data go to 0.
  - o_mem_addr, o_mem_wdata, o_mem_wmask go to 0.
  - Any in-flight transaction is abandoned without an ack; memory must tolerate this.
- State machine: IDLE, BUSY_FETCH, BUSY_DATA.
- IDLE:
  - Requests are sampled here only. No request: stay in IDLE.
  - On a grant: register address, data, mask and we, set o_mem_req=1 on the next edge, and move to BUSY_x.
  - Request to bus latency: 1 cycle.
- Grant choice when both requesters are pending:
  - The preferred requester (per DATA_PRIORITY) wins unless starve_cnt==STARVE_LIMIT, in which case the other requester wins.
  - starve_cnt increments when the preferred requester wins while the other is pending; saturates at STARVE_LIMIT.
  - starve_cnt clears when the non-preferred requester is granted.
  - A sole requester always wins and leaves starve_cnt unchanged.
- Data request with i_read_req and i_write_req both high: treated as a write (write has priority); the read stays pending for a later grant.
- BUSY_x:
  - o_mem_req is held high and the registered fields are held stable until i_mem_ack.
  - The cycle i_mem_ack=1: the owner's ack is driven combinationally high for exactly that cycle, and i_mem_rdata is passed through to o_inst_read or o_data_read.
  - The next edge drops o_mem_req and returns to IDLE.
  - Minimum bus turnaround: 1 idle cycle between transactions.
- i_mem_ack while in IDLE: ignored, no ack generated.
- Requests are not monitored in BUSY. Dropping a request before its ack violates the protocol; the result is undefined.
- Non-owner acks are 0 at all times. o_inst_read and o_data_read are 0 whenever their ack is 0.

Test Plan:
1. Reset then lone fetch at 0x0000_0100; memory acks 2 cycles after o_mem_req rises with 0xDEADBEEF -> o_mem_req rises 1 cycle after the request; o_mem_addr=0x100, we=0, wmask=0; o_fetch_ack pulses 1 cycle with o_inst_read=0xDEADBEEF; back to IDLE.
2. Simultaneous fetch 0x200 and write 0x8000_0004 (data 0x1234_5678, mask 4'b0011), DATA_PRIORITY=1, immediate memory acks -> the write is granted first with we=1 and wmask=0011, o_write_ack pulses; the fetch is granted next and o_fetch_ack pulses.
3. Fetch held pending while a data read is re-requested every cycle after each ack, STARVE_LIMIT=4 -> exactly 4 data grants, then the fetch is granted 5th; starve_cnt clears after the fetch grant.
4. i_read_req and i_write_req both high at 0x40 -> the write completes first (o_write_ack only), then the read is granted and o_read_ack pulses with i_mem_rdata.
5. i_rst driven low during BUSY_DATA with no ack pending -> next cycle o_mem_req=0, all acks 0, IDLE; a later i_mem_ack pulse produces no requester ack.
6. DATA_PRIORITY=0 with simultaneous fetch and read -> the fetch wins first; after 4 consecutive fetch wins with the read pending, the read is forced through.
